// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine front-end.
package vend_pkg;

  // Sequencer states; REFUND is only reachable when VEND_CANCEL_EN is defined.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    REFUND   = 3'd4
  } state_t;

  localparam logic [1:0] ITEM_NONE = 2'd0;
  localparam logic [1:0] ITEM_1    = 2'd1;
  localparam logic [1:0] ITEM_2    = 2'd2;
  localparam logic [1:0] ITEM_3    = 2'd3;

  // Prices in nickels.
  localparam int DEF_PRICE_1  = 3;
  localparam int DEF_PRICE_2  = 4;
  localparam int DEF_PRICE_3  = 5;
  localparam int DEF_CREDIT_W = 3;

endpackage

// File: rtl/vend_change_counter.sv
// Loadable down-counter that pays out nickels one per cycle while active.
// Used for both overpayment change and cancel refunds.
module vend_change_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         active,
  output logic         nickel_out,
  output logic         done,
  output logic         zero
);

  logic [W-1:0] count;

  // Load on entry to a payout, then count down one nickel per active cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (active && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign nickel_out = active && (count != '0);
  // The last nickel is being paid this cycle.
  assign done       = (count == W'(1));
  assign zero       = (count == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending machine front-end: item latch, shared coin credit datapath and
// a single Moore sequencer. Optional cancel/refund is built when the macro
// VEND_CANCEL_EN is defined; otherwise cancel is ignored.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for a valid selection; coins are rejected
// COLLECT  | accumulating credit against the latched item's price
// DISPENSE | one-cycle release pulse for the latched item
// CHANGE   | paying back overpayment, one nickel per cycle
// REFUND   | paying back all credit after cancel (VEND_CANCEL_EN)
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_1  = DEF_PRICE_1,
  parameter int PRICE_2  = DEF_PRICE_2,
  parameter int PRICE_3  = DEF_PRICE_3,
  parameter int CREDIT_W = DEF_CREDIT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] item_sel,
  input  logic       sel_valid,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       cancel,
  output logic       dispense,
  output logic [1:0] item_code,
  output logic       nickel_out,
  output logic       coin_reject,
  output logic       busy
);

  state_t              state, state_next;
  logic [1:0]          item_q;
  logic [CREDIT_W-1:0] price_q, credit_q, credit_next, sel_price, load_value;
  logic [CREDIT_W:0]   credit_sum;
  logic                pay_done, load_change, take_sel;
  logic                change_active, change_done, change_zero;
  logic                coin_reject_q;

`ifndef VEND_CANCEL_EN
  logic unused_cancel;
  assign unused_cancel = cancel;
`endif

  // Extra bit keeps price+2 overpayment from wrapping before the compare.
  assign credit_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(nickel_in)
                     + (CREDIT_W+1)'({dime_in, 1'b0});
  assign credit_next = credit_sum[CREDIT_W-1:0];
  assign pay_done    = (credit_sum >= {1'b0, price_q});
  assign take_sel    = (state == IDLE) && sel_valid && (item_sel != ITEM_NONE);

  // Price lookup for the item being selected.
  always_comb begin
    sel_price = '0;
    case (item_sel)
      ITEM_1:  sel_price = CREDIT_W'(PRICE_1);
      ITEM_2:  sel_price = CREDIT_W'(PRICE_2);
      ITEM_3:  sel_price = CREDIT_W'(PRICE_3);
      default: sel_price = '0;
    endcase
  end

  // Next-state decode and change-counter load control.
  always_comb begin
    state_next  = state;
    load_change = 1'b0;
    load_value  = credit_next - price_q;
    case (state)
      IDLE: begin
        if (take_sel) state_next = COLLECT;
      end
      COLLECT: begin
`ifdef VEND_CANCEL_EN
        if (cancel) begin
          if (credit_sum != '0) begin
            state_next  = REFUND;
            load_change = 1'b1;
            load_value  = credit_next;
          end else begin
            state_next = IDLE;
          end
        end else
`endif
        if (pay_done) begin
          state_next  = DISPENSE;
          load_change = 1'b1;
        end
      end
      DISPENSE: begin
        state_next = change_zero ? IDLE : CHANGE;
      end
      CHANGE: begin
        if (change_done) state_next = IDLE;
      end
`ifdef VEND_CANCEL_EN
      REFUND: begin
        if (change_done) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State, selection latch, credit and coin-reject registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      item_q        <= ITEM_NONE;
      price_q       <= '0;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state         <= state_next;
      coin_reject_q <= (nickel_in || dime_in) && (state != COLLECT);
      if (take_sel) begin
        item_q  <= item_sel;
        price_q <= sel_price;
      end
      credit_q <= ((state == COLLECT) && (state_next == COLLECT)) ? credit_next : '0;
    end
  end

`ifdef VEND_CANCEL_EN
  assign change_active = (state == CHANGE) || (state == REFUND);
`else
  assign change_active = (state == CHANGE);
`endif

  vend_change_counter #(.W(CREDIT_W)) u_change (
    .clock      (clock),
    .reset      (reset),
    .load       (load_change),
    .load_value (load_value),
    .active     (change_active),
    .nickel_out (nickel_out),
    .done       (change_done),
    .zero       (change_zero)
  );

  assign dispense    = (state == DISPENSE);
  assign item_code   = dispense ? item_q : ITEM_NONE;
  assign coin_reject = coin_reject_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a timeline model.
module tb_vend_controller;

  logic       clock = 1'b0;
  logic       reset, sel_valid, nickel_in, dime_in, cancel;
  logic [1:0] item_sel;
  logic       dispense, nickel_out, coin_reject, busy;
  logic [1:0] item_code;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef VEND_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  vend_controller dut (
    .clock       (clock),
    .reset       (reset),
    .item_sel    (item_sel),
    .sel_valid   (sel_valid),
    .nickel_in   (nickel_in),
    .dime_in     (dime_in),
    .cancel      (cancel),
    .dispense    (dispense),
    .item_code   (item_code),
    .nickel_out  (nickel_out),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Model: a collecting flag with credit, plus a queue of the outputs that
  // each future cycle must show once a purchase or refund is settled.
  typedef struct {
    bit disp;
    int item;
    bit nick;
  } ev_t;

  ev_t sched[$];
  bit  m_coll;
  int  m_item, m_price, m_credit;
  bit  e_disp, e_nick, e_busy, e_rej;
  int  e_item;

  function automatic int price_of(input int it);
    return (it == 1) ? 3 : (it == 2) ? 4 : 5;
  endfunction

  task automatic push_ev(input bit d, input int it, input bit nk);
    ev_t ev;
    ev.disp = d;
    ev.item = it;
    ev.nick = nk;
    sched.push_back(ev);
  endtask

  task automatic model_step(input bit r, input bit sv, input int is,
                            input bit n, input bit d, input bit c);
    ev_t ev;
    bit  rej_n;
    if (r) begin
      m_coll = 0; m_credit = 0; sched.delete();
      e_disp = 0; e_item = 0; e_nick = 0; e_busy = 0; e_rej = 0;
      return;
    end
    rej_n = (n || d) && !m_coll;
    if (!e_busy) begin
      if (sv && is != 0) begin
        m_coll = 1; m_item = is; m_price = price_of(is); m_credit = 0;
      end
    end else if (m_coll) begin
      m_credit += int'(n) + 2 * int'(d);
      if (CANCEL_EN && c) begin
        m_coll = 0;
        for (int k = 0; k < m_credit; k++) push_ev(0, 0, 1);
      end else if (m_credit >= m_price) begin
        m_coll = 0;
        push_ev(1, m_item, 0);
        for (int k = 0; k < m_credit - m_price; k++) push_ev(0, 0, 1);
      end
    end
    e_rej = rej_n;
    if (sched.size() > 0) begin
      ev = sched.pop_front();
      e_disp = ev.disp; e_item = ev.item; e_nick = ev.nick;
      e_busy = 1;
    end else begin
      e_disp = 0; e_item = 0; e_nick = 0;
      e_busy = m_coll;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs.
  task automatic tick(input bit r, input bit sv, input bit [1:0] is,
                      input bit n, input bit d, input bit c);
    reset = r; sel_valid = sv; item_sel = is;
    nickel_in = n; dime_in = d; cancel = c;
    model_step(r, sv, int'(is), n, d, c);
    @(posedge clock);
    #1;
    check("dispense",    int'(dispense),    int'(e_disp));
    check("item_code",   int'(item_code),   e_item);
    check("nickel_out",  int'(nickel_out),  int'(e_nick));
    check("coin_reject", int'(coin_reject), int'(e_rej));
    check("busy",        int'(busy),        int'(e_busy));
  endtask

  task automatic idle_tick();
    tick(0, 0, 2'd0, 0, 0, 0);
  endtask

  int nick_cnt;
  int disp_cnt;

  initial begin
    reset = 1; sel_valid = 0; item_sel = 0;
    nickel_in = 0; dime_in = 0; cancel = 0;
    m_coll = 0; m_credit = 0; m_item = 0; m_price = 0;
    e_disp = 0; e_item = 0; e_nick = 0; e_busy = 0; e_rej = 0;

    tick(1, 0, 2'd0, 0, 0, 0);
    tick(1, 0, 2'd0, 1, 0, 0);
    check("rst_dispense", int'(dispense), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_nickel_out", int'(nickel_out), 0);
    check("rst_coin_reject", int'(coin_reject), 0);

    // Exact pay for item 1.
    tick(0, 1, 2'd1, 0, 0, 0);
    tick(0, 0, 2'd0, 1, 0, 0);
    tick(0, 0, 2'd0, 0, 1, 0);
    check("t1_dispense", int'(dispense), 1);
    check("t1_item", int'(item_code), 1);
    idle_tick();
    check("t1_busy_after", int'(busy), 0);
    check("t1_no_change", int'(nickel_out), 0);

    // Overpay with nickel+dime together on item 3: two change nickels.
    tick(0, 1, 2'd3, 0, 0, 0);
    tick(0, 0, 2'd0, 0, 1, 0);
    tick(0, 0, 2'd0, 0, 1, 0);
    tick(0, 0, 2'd0, 1, 1, 0);
    check("t2_dispense", int'(dispense), 1);
    check("t2_item", int'(item_code), 3);
    idle_tick();
    check("t2_nick1", int'(nickel_out), 1);
    idle_tick();
    check("t2_nick2", int'(nickel_out), 1);
    idle_tick();
    check("t2_nick_end", int'(nickel_out), 0);
    check("t2_busy_end", int'(busy), 0);

    // Coin while idle is rejected.
    tick(0, 0, 2'd0, 1, 0, 0);
    check("t3_reject", int'(coin_reject), 1);
    check("t3_busy", int'(busy), 0);
    idle_tick();
    check("t3_reject_end", int'(coin_reject), 0);

    // Invalid selection, then a selection change attempt during COLLECT.
    tick(0, 1, 2'd0, 0, 0, 0);
    check("t4_invalid_sel", int'(busy), 0);
    tick(0, 1, 2'd2, 0, 0, 0);
    tick(0, 1, 2'd3, 0, 0, 0);
    for (int k = 0; k < 4; k++) tick(0, 0, 2'd0, 1, 0, 0);
    check("t4_dispense", int'(dispense), 1);
    check("t4_item", int'(item_code), 2);
    idle_tick();
    check("t4_busy_end", int'(busy), 0);

    // Reset in the middle of a purchase.
    tick(0, 1, 2'd2, 0, 0, 0);
    tick(0, 0, 2'd0, 0, 1, 0);
    tick(1, 0, 2'd0, 0, 0, 0);
    check("t5_busy", int'(busy), 0);
    check("t5_nickel_out", int'(nickel_out), 0);
    check("t5_dispense", int'(dispense), 0);
    tick(0, 0, 2'd0, 1, 0, 0);
    check("t5_reject", int'(coin_reject), 1);
    idle_tick();

    // Cancel after partial payment on item 3.
    tick(0, 1, 2'd3, 0, 0, 0);
    tick(0, 0, 2'd0, 0, 1, 0);
    tick(0, 0, 2'd0, 1, 0, 0);
    tick(0, 0, 2'd0, 0, 0, 1);
`ifdef VEND_CANCEL_EN
    nick_cnt = 0;
    disp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      nick_cnt += int'(nickel_out);
      disp_cnt += int'(dispense);
      idle_tick();
    end
    check("t6_refund_nickels", nick_cnt, 3);
    check("t6_no_dispense", disp_cnt, 0);
`else
    check("t6_busy_held", int'(busy), 1);
    check("t6_no_refund", int'(nickel_out), 0);
    tick(0, 0, 2'd0, 0, 1, 0);
    check("t6_dispense", int'(dispense), 1);
    check("t6_item", int'(item_code), 3);
    idle_tick();
`endif
    idle_tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Front-end sequencer for the three-item nickel/dime vending machine.
- Latches a customer item selection, accumulates coin credit in nickel units against that item's price, and issues a one-cycle dispense pulse.
- Returns any overpayment as a train of single-cycle nickel_out pulses, then returns to idle.
- Replaces the per-item coin FSMs with one shared credit datapath, sequenced by a single Moore FSM.

Parameters:
- PRICE_1, 3, price of item 1 in nickels (15c)
- PRICE_2, 4, price of item 2 in nickels (20c)
- PRICE_3, 5, price of item 3 in nickels (25c)
- CREDIT_W, 3, width of credit and change counters; must hold max(PRICE_n)+2

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- item_sel  input  2  item code: 1, 2, 3 valid; 0 invalid
- sel_valid  input  1  item_sel qualifier; single-cycle strobe
- nickel_in  input  1  one nickel inserted this cycle
- dime_in  input  1  one dime inserted this cycle
- cancel  input  1  refund request; used only with VEND_CANCEL_EN
- dispense  output  1  one-cycle pulse: release the latched item
- item_code  output  2  latched item; valid while dispense=1, else 0
- nickel_out  output  1  one nickel returned per asserted cycle
- coin_reject  output  1  one-cycle pulse the cycle after an ignored coin
- busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high; when sampled high at a rising edge, it overrides all other inputs that cycle.
- Reset values: state=IDLE, credit=0, change=0, latched item=0. All outputs are 0.
- Outputs are decoded from registered state and counters (Moore).
- FSM states: IDLE, COLLECT, DISPENSE, CHANGE, plus REFUND (only with VEND_CANCEL_EN).
- IDLE:
  - sel_valid with item_sel in 1..3: latch item and price, credit=0, go to COLLECT.
  - item_sel=0 with sel_valid: ignored; stay IDLE.
  - Any coin: ignored; coin_reject=1 next cycle.
- COLLECT:
  - Per cycle, credit += nickel_in + 2*dime_in. Both asserted in one cycle adds 3.
  - When updated credit >= price: go to DISPENSE and load change = updated credit - price.
  - sel_valid in COLLECT is ignored; the selection cannot be changed.
- DISPENSE: held exactly 1 cycle. dispense=1, item_code=latched item. Coins ignored (coin_reject).
  - change=0: go to IDLE.
  - change>0: go to CHANGE.
- CHANGE: nickel_out=1 every cycle; change decrements by 1 per cycle. When change reaches 1, next state is IDLE (exactly 'change' pulses). Coins ignored (coin_reject).
- Latency: payment completing in cycle N gives dispense in cycle N+1 and the first nickel_out in cycle N+2.
- Max overpay: credit price-1 plus dime+nickel in the same cycle gives change=2. Counters never exceed price+2.
- Reset mid-vend (any state): no dispense and no refund are issued; all credit is lost. This is intentional, since reset models power-up.

Optional Feature:
- Macro: VEND_CANCEL_EN.
- Defined:
  - cancel=1 in COLLECT with credit>0: go to REFUND, change=credit. REFUND emits nickel_out per cycle like CHANGE, then goes to IDLE; dispense never asserts.
  - cancel=1 in COLLECT with credit=0: go to IDLE directly.
  - cancel and a completing coin in the same cycle: the coin is counted and cancel wins, so the full credit is refunded.
  - cancel outside COLLECT: ignored.
- Not defined: cancel port is present but ignored. REFUND state is not built. A selection is held until it is paid.

Decomposition:
- Package vend_pkg holds:
  - state enum (IDLE, COLLECT, DISPENSE, CHANGE, REFUND)
  - item code constants ITEM_NONE=0, ITEM_1..ITEM_3
  - default price constants
- Natural sub-module: vend_change_counter, a loadable down-counter with an nickel_out/done interface. It is shared by the CHANGE and REFUND states.

Test Plan:
1. Exact pay: sel item1, then nickel, dime over 2 cycles -> dispense=1 with item_code=1 one cycle after the dime; no nickel_out; busy=0 the next cycle.
2. Overpay with simultaneous coins: sel item3, dime, dime, then nickel+dime together (credit 7) -> dispense, then exactly 2 nickel_out pulses on consecutive cycles, then IDLE.
3. Idle coins: nickel in IDLE -> coin_reject pulse one cycle later; credit stays 0; busy stays 0.
4. Invalid and late selection: sel_valid with item_sel=0 -> stays IDLE. Sel item2, then sel item3 while in COLLECT -> price stays 4, and 4 nickels give dispense with item_code=2.
5. Reset mid-vend: sel item2, dime, then reset -> all outputs 0 next cycle, no nickel_out; then nickel alone gives coin_reject.
6. VEND_CANCEL_EN: sel item3, dime, nickel, cancel -> 3 nickel_out pulses, no dispense. Without the macro, the same stimulus -> cancel ignored and COLLECT is held.
